// File: rtl/h_bram_loader.sv
// Host stream -> five GAT input BRAMs load sequencer.
// Fills col_idx, value, node_info, Weight and a in order, then flags each segment complete.
module h_bram_loader #(
    parameter int DATA_WIDTH       = 8,
    parameter int COL_IDX_WIDTH    = 11,
    parameter int NODE_INFO_WIDTH  = 21,
    parameter int IN_WIDTH         = 32,
    parameter int COL_IDX_DEPTH    = 242101,
    parameter int VALUE_DEPTH      = 242101,
    parameter int NODE_INFO_DEPTH  = 13264,
    parameter int WEIGHT_DEPTH     = 22928,
    parameter int A_DEPTH          = 32,
    localparam int COL_IDX_ADDR_W   = $clog2(COL_IDX_DEPTH),
    localparam int VALUE_ADDR_W     = $clog2(VALUE_DEPTH),
    localparam int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
    localparam int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH),
    localparam int A_ADDR_W         = $clog2(A_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [IN_WIDTH-1:0]         s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [COL_IDX_WIDTH-1:0]    H_col_idx_BRAM_din,
    output logic                        H_col_idx_BRAM_ena,
    output logic [COL_IDX_ADDR_W-1:0]   H_col_idx_BRAM_addra,
    output logic [DATA_WIDTH-1:0]       H_value_BRAM_din,
    output logic                        H_value_BRAM_ena,
    output logic [VALUE_ADDR_W-1:0]     H_value_BRAM_addra,
    output logic [NODE_INFO_WIDTH-1:0]  H_node_info_BRAM_din,
    output logic                        H_node_info_BRAM_ena,
    output logic [NODE_INFO_ADDR_W-1:0] H_node_info_BRAM_addra,
    output logic [DATA_WIDTH-1:0]       Weight_BRAM_din,
    output logic                        Weight_BRAM_ena,
    output logic [WEIGHT_ADDR_W-1:0]    Weight_BRAM_addra,
    output logic [DATA_WIDTH-1:0]       a_BRAM_din,
    output logic                        a_BRAM_ena,
    output logic [A_ADDR_W-1:0]         a_BRAM_addra,
    output logic                        H_col_idx_BRAM_load_done,
    output logic                        H_value_BRAM_load_done,
    output logic                        H_node_info_BRAM_load_done,
    output logic                        Weight_BRAM_load_done,
    output logic                        a_BRAM_load_done,
    output logic                        busy,
    output logic                        done
);

    localparam int M1    = (COL_IDX_ADDR_W > VALUE_ADDR_W) ? COL_IDX_ADDR_W : VALUE_ADDR_W;
    localparam int M2    = (M1 > NODE_INFO_ADDR_W) ? M1 : NODE_INFO_ADDR_W;
    localparam int M3    = (M2 > WEIGHT_ADDR_W) ? M2 : WEIGHT_ADDR_W;
    localparam int M4    = (M3 > A_ADDR_W) ? M3 : A_ADDR_W;
    localparam int CNT_W = (M4 < 1) ? 1 : M4;

    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COL_IDX_DEPTH - 1);
    localparam logic [CNT_W-1:0] VAL_LAST  = CNT_W'(VALUE_DEPTH - 1);
    localparam logic [CNT_W-1:0] INFO_LAST = CNT_W'(NODE_INFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] W_LAST    = CNT_W'(WEIGHT_DEPTH - 1);
    localparam logic [CNT_W-1:0] A_LAST    = CNT_W'(A_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_COL  = 3'd1,
        LD_VAL  = 3'd2,
        LD_INFO = 3'd3,
        LD_W    = 3'd4,
        LD_A    = 3'd5,
        FIN     = 3'd6
    } state_t;

    state_t               state_q, state_d, seg_next;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4:0]           seg_sel;
    logic                 seg_end;
    logic                 in_load;
    logic                 hs;
    logic [4:0]           ena_q, ena_d;
    logic [4:0]           last_q, last_d;
    logic [4:0]           flag_q, flag_d;
    logic [IN_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [CNT_W-1:0]     wr_addr_q, wr_addr_d;
    logic                 done_q, done_d;
    logic                 unused_ok;

    // Segment bit order throughout: 0 col_idx, 1 value, 2 node_info, 3 Weight, 4 a.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seg_sel   = 5'b00000;
        seg_end   = 1'b0;
        seg_next  = IDLE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_COL;
                    cnt_d   = '0;
                end
            end
            LD_COL:  begin seg_sel = 5'b00001; seg_end = (cnt_q == COL_LAST);  seg_next = LD_VAL;  end
            LD_VAL:  begin seg_sel = 5'b00010; seg_end = (cnt_q == VAL_LAST);  seg_next = LD_INFO; end
            LD_INFO: begin seg_sel = 5'b00100; seg_end = (cnt_q == INFO_LAST); seg_next = LD_W;    end
            LD_W:    begin seg_sel = 5'b01000; seg_end = (cnt_q == W_LAST);    seg_next = LD_A;    end
            LD_A:    begin seg_sel = 5'b10000; seg_end = (cnt_q == A_LAST);    seg_next = FIN;     end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_load = |seg_sel;
        hs      = s_valid & in_load;

        if (hs) begin
            if (seg_end) begin
                cnt_d   = '0;
                state_d = seg_next;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        ena_d     = hs ? seg_sel : 5'b00000;
        last_d    = (hs && seg_end) ? seg_sel : 5'b00000;
        wr_data_d = hs ? s_data : wr_data_q;
        wr_addr_d = hs ? cnt_q : wr_addr_q;
        flag_d    = flag_q | last_q;
        if (state_q == IDLE && start) begin
            flag_d = 5'b00000;
        end
        done_d = (state_q == FIN);

        // Abort kills the pending handshake, queued flag sets and the done pulse.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            ena_d   = 5'b00000;
            last_d  = 5'b00000;
            flag_d  = 5'b00000;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ena_q     <= 5'b00000;
            last_q    <= 5'b00000;
            flag_q    <= 5'b00000;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ena_q     <= ena_d;
            last_q    <= last_d;
            flag_q    <= flag_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
        end
    end

    assign s_ready = in_load;
    assign busy    = in_load;
    assign done    = done_q;

    // Shared data/address register fans out; each BRAM keeps only its low bits.
    assign H_col_idx_BRAM_din     = wr_data_q[COL_IDX_WIDTH-1:0];
    assign H_col_idx_BRAM_ena     = ena_q[0];
    assign H_col_idx_BRAM_addra   = wr_addr_q[COL_IDX_ADDR_W-1:0];
    assign H_value_BRAM_din       = wr_data_q[DATA_WIDTH-1:0];
    assign H_value_BRAM_ena       = ena_q[1];
    assign H_value_BRAM_addra     = wr_addr_q[VALUE_ADDR_W-1:0];
    assign H_node_info_BRAM_din   = wr_data_q[NODE_INFO_WIDTH-1:0];
    assign H_node_info_BRAM_ena   = ena_q[2];
    assign H_node_info_BRAM_addra = wr_addr_q[NODE_INFO_ADDR_W-1:0];
    assign Weight_BRAM_din        = wr_data_q[DATA_WIDTH-1:0];
    assign Weight_BRAM_ena        = ena_q[3];
    assign Weight_BRAM_addra      = wr_addr_q[WEIGHT_ADDR_W-1:0];
    assign a_BRAM_din             = wr_data_q[DATA_WIDTH-1:0];
    assign a_BRAM_ena             = ena_q[4];
    assign a_BRAM_addra           = wr_addr_q[A_ADDR_W-1:0];

    assign H_col_idx_BRAM_load_done   = flag_q[0];
    assign H_value_BRAM_load_done     = flag_q[1];
    assign H_node_info_BRAM_load_done = flag_q[2];
    assign Weight_BRAM_load_done      = flag_q[3];
    assign a_BRAM_load_done           = flag_q[4];

    assign unused_ok = ^{wr_data_q, wr_addr_q};

endmodule

// File: tb/tb_h_bram_loader.sv
// Directed bench for h_bram_loader with small depths (4/4/2/3/2).
// A negedge monitor records BRAM writes; the main sequence checks timing and contents.
module tb_h_bram_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, s_valid;
    logic [31:0] s_data;
    logic        s_ready, busy, done;
    logic [10:0] col_din;
    logic [7:0]  val_din, w_din, a_din;
    logic [20:0] info_din;
    logic        col_ena, val_ena, info_ena, w_ena, a_ena;
    logic [1:0]  col_addr, val_addr, w_addr;
    logic [0:0]  info_addr, a_addr;
    logic        col_done, val_done, info_done, w_done, a_done;
    logic        any_out, any_ena;

    int total = 0;
    int passed = 0;
    int failed = 0;

    logic [31:0] m_col[4];
    logic [31:0] m_val[4];
    logic [31:0] m_info[2];
    logic [31:0] m_w[3];
    logic [31:0] m_a[2];
    int n_col, n_val, n_info, n_w, n_a, n_done;

    always #5 clk = ~clk;

    h_bram_loader #(
        .DATA_WIDTH(8), .COL_IDX_WIDTH(11), .NODE_INFO_WIDTH(21), .IN_WIDTH(32),
        .COL_IDX_DEPTH(4), .VALUE_DEPTH(4), .NODE_INFO_DEPTH(2),
        .WEIGHT_DEPTH(3), .A_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .H_col_idx_BRAM_din(col_din), .H_col_idx_BRAM_ena(col_ena), .H_col_idx_BRAM_addra(col_addr),
        .H_value_BRAM_din(val_din), .H_value_BRAM_ena(val_ena), .H_value_BRAM_addra(val_addr),
        .H_node_info_BRAM_din(info_din), .H_node_info_BRAM_ena(info_ena), .H_node_info_BRAM_addra(info_addr),
        .Weight_BRAM_din(w_din), .Weight_BRAM_ena(w_ena), .Weight_BRAM_addra(w_addr),
        .a_BRAM_din(a_din), .a_BRAM_ena(a_ena), .a_BRAM_addra(a_addr),
        .H_col_idx_BRAM_load_done(col_done), .H_value_BRAM_load_done(val_done),
        .H_node_info_BRAM_load_done(info_done), .Weight_BRAM_load_done(w_done),
        .a_BRAM_load_done(a_done), .busy(busy), .done(done)
    );

    assign any_ena = |{col_ena, val_ena, info_ena, w_ena, a_ena};
    assign any_out = |{s_ready, busy, done, col_din, col_ena, col_addr, val_din, val_ena, val_addr,
                       info_din, info_ena, info_addr, w_din, w_ena, w_addr, a_din, a_ena, a_addr,
                       col_done, val_done, info_done, w_done, a_done};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] d);
        s_data  = d;
        s_valid = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            m_col[k] = 32'hAAAA_AAAA;
            m_val[k] = 32'hAAAA_AAAA;
        end
        for (int k = 0; k < 3; k++) m_w[k] = 32'hAAAA_AAAA;
        for (int k = 0; k < 2; k++) begin
            m_info[k] = 32'hAAAA_AAAA;
            m_a[k]    = 32'hAAAA_AAAA;
        end
        n_col = 0; n_val = 0; n_info = 0; n_w = 0; n_a = 0; n_done = 0;
    endtask

    task automatic check_seq_contents(input logic [31:0] base);
        for (int k = 0; k < 4; k++) check("col_mem", m_col[k], base + k);
        for (int k = 0; k < 4; k++) check("val_mem", m_val[k], base + 4 + k);
        for (int k = 0; k < 2; k++) check("info_mem", m_info[k], base + 8 + k);
        for (int k = 0; k < 3; k++) check("w_mem", m_w[k], base + 10 + k);
        for (int k = 0; k < 2; k++) check("a_mem", m_a[k], base + 13 + k);
        check("write_counts", {n_col[7:0], n_val[7:0], n_info[7:0], n_w[3:0], n_a[3:0]},
              {8'd4, 8'd4, 8'd2, 4'd3, 4'd2});
        check("done_pulses", n_done, 1);
    endtask

    // Write monitor: addresses within each BRAM must be consecutive from 0.
    initial begin
        forever begin
            @(negedge clk);
            if (any_ena)
                check("ena_onehot", $countones({col_ena, val_ena, info_ena, w_ena, a_ena}), 1);
            if (col_ena)  begin check("col_addr",  32'(col_addr),  n_col % 4);  m_col[col_addr]   = 32'(col_din);  n_col++;  end
            if (val_ena)  begin check("val_addr",  32'(val_addr),  n_val % 4);  m_val[val_addr]   = 32'(val_din);  n_val++;  end
            if (info_ena) begin check("info_addr", 32'(info_addr), n_info % 2); m_info[info_addr] = 32'(info_din); n_info++; end
            if (w_ena)    begin check("w_addr",    32'(w_addr),    n_w % 3);    if (w_addr < 2'd3) m_w[w_addr] = 32'(w_din); n_w++; end
            if (a_ena)    begin check("a_addr",    32'(a_addr),    n_a % 2);    m_a[a_addr]       = 32'(a_din);    n_a++;    end
            if (done) n_done++;
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        clear_model();
        step();
        step();
        check("reset_all_zero", any_out, 0);
        rst_n = 1'b1;
        step();
        check("idle_s_ready", s_ready, 0);
        check("idle_busy", busy, 0);

        // Back-to-back stream 0..14
        clear_model();
        pulse_start();
        check("b2b_busy_after_start", busy, 1);
        check("b2b_ready_after_start", s_ready, 1);
        for (int i = 0; i < 15; i++) begin
            feed(i);
            check("b2b_ena_follows", any_ena, 1);
            check("b2b_s_ready", s_ready, 32'(i < 14));
            check("b2b_col_done", col_done, 32'(i >= 4));
            check("b2b_val_done", val_done, 32'(i >= 8));
            check("b2b_info_done", info_done, 32'(i >= 10));
            check("b2b_w_done", w_done, 32'(i >= 13));
            check("b2b_a_done", a_done, 0);
            check("b2b_done_low", done, 0);
        end
        s_valid = 1'b0;
        check("b2b_busy_fin", busy, 0);
        step();
        check("b2b_done_pulse", done, 1);
        check("b2b_a_done_rise", a_done, 1);
        step();
        check("b2b_done_one_cycle", done, 0);
        check("b2b_a_done_sticky", a_done, 1);
        check("b2b_all_flags", {col_done, val_done, info_done, w_done}, 4'b1111);
        step();
        check_seq_contents(0);

        // Gapped stream: valid 1,0,1,0
        clear_model();
        pulse_start();
        check("gap_flags_cleared", {col_done, val_done, info_done, w_done, a_done}, 0);
        for (int i = 0; i < 15; i++) begin
            feed(i);
            check("gap_ena_on_hs", any_ena, 1);
            s_valid = 1'b0;
            s_data  = 32'h0000_BEEF;
            step();
            check("gap_ena_idle", any_ena, 0);
        end
        step();
        step();
        check("gap_a_done", a_done, 1);
        check_seq_contents(0);

        // Width truncation with all-ones words
        clear_model();
        pulse_start();
        for (int i = 0; i < 15; i++) feed(32'hFFFF_FFFF);
        s_valid = 1'b0;
        step();
        step();
        check("trunc_col", m_col[3], 32'h0000_07FF);
        check("trunc_val", m_val[0], 32'h0000_00FF);
        check("trunc_info", m_info[1], 32'h001F_FFFF);
        check("trunc_w", m_w[2], 32'h0000_00FF);
        check("trunc_a", m_a[0], 32'h0000_00FF);
        check("trunc_done", n_done, 1);

        // Abort after two value words, with a valid word pending in the abort cycle
        clear_model();
        pulse_start();
        for (int i = 0; i < 6; i++) feed(i);
        check("abort_pre_col_done", col_done, 1);
        check("abort_pre_busy", busy, 1);
        abort  = 1'b1;
        s_data = 32'd77;
        step();
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_ready", s_ready, 0);
        check("abort_no_write", any_ena, 0);
        check("abort_flags_clear", {col_done, val_done, info_done, w_done, a_done}, 0);
        step();
        step();
        step();
        check("abort_no_done", n_done, 0);
        check("abort_val_writes", n_val, 2);
        clear_model();
        pulse_start();
        for (int i = 0; i < 15; i++) feed(100 + i);
        s_valid = 1'b0;
        step();
        step();
        check_seq_contents(100);

        // Start during LD_INFO is ignored
        clear_model();
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            start = (i == 8);
            feed(i);
        end
        start   = 1'b0;
        s_valid = 1'b0;
        step();
        step();
        check("ign_a_done", a_done, 1);
        check_seq_contents(0);

        // Asynchronous reset in the middle of LD_VAL
        clear_model();
        pulse_start();
        for (int i = 0; i < 5; i++) feed(i);
        check("rst_pre_ena", val_ena, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_all_zero", any_out, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_post_ready", s_ready, 0);
        check("rst_post_busy", busy, 0);
        check("rst_post_no_write", any_ena, 0);
        check("rst_post_flags", {col_done, val_done, info_done, w_done, a_done}, 0);
        s_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
